ddr_arbiter: RTL and testbench
==============================

// Module: ddr_arbiter
// PURPOSE
//  Two-port arbiter sharing the single DDR Avalon master (DDRAM_*) between requesters,
//  e.g. port 0 = ROM download/tile fetch, port 1 = frame buffer writer/reader.
//  Sits between the requesting blocks and the top-level DDR pins. Grants a whole burst at a
//  time and uses round-robin priority so neither port starves.
// PARAMETERS
//  ADDR_WIDTH   32  byte address width (top level drops addr[2:0])
//  DATA_WIDTH   64  data beat width
//  BURST_WIDTH  8   burst count width
// PORTS  (N = 0,1)
//  clock               in   1     system clock (clk_sys domain)
//  reset               in   1     asynchronous, active-high
//  io_in_N_rd          in   1     read request, held until accepted (waitReq low)
//  io_in_N_wr          in   1     write beat valid
//  io_in_N_addr        in   AW    burst start address
//  io_in_N_burstCount  in   BW    beats in burst; 0 treated as 1
//  io_in_N_mask        in   DW/8  byte enables
//  io_in_N_din         in   DW    write data
//  io_in_N_waitReq     out  1     stall to requester
//  io_in_N_valid       out  1     read data beat valid
//  io_in_N_dout        out  DW    read data (io_ddr_dout fanned out)
//  io_ddr_rd/wr        out  1     to DDR
//  io_ddr_addr         out  AW    to DDR
//  io_ddr_burstCount   out  BW    to DDR
//  io_ddr_mask         out  DW/8  to DDR
//  io_ddr_din          out  DW    to DDR
//  io_ddr_dout         in   DW    from DDR
//  io_ddr_waitReq      in   1     DDR busy
//  io_ddr_valid        in   1     DDR read beat valid
// BEHAVIOUR
//  Clock: single clock. Reset: asynchronous, active-high. Reset state: IDLE, grant=0,
//  prio=0, beat counter=0. All io_ddr_rd/wr=0; both io_in_N_waitReq=1; io_in_N_valid=0.
//  States:
//   IDLE:   io_ddr_rd/wr=0; both waitReq=1. If any (rd|wr) pending: grant <= winner,
//           go to ACTIVE. Winner: the only requester, or prio port if both request.
//   ACTIVE: granted port muxed through: io_ddr_* = io_in_g_*,
//           io_in_g_waitReq = io_ddr_waitReq. Other port waitReq=1.
//           Read accept (rd & !io_ddr_waitReq):
//             count <= burstCount (0 -> 1); go to READ.
//           Write accept (wr & !io_ddr_waitReq), first beat:
//             count <= burstCount-1 (0 or 1 -> burst done, go to IDLE); else go to WRITE.
//   READ:   io_ddr_rd=0; both waitReq=1. Each io_ddr_valid: io_in_g_valid=1, count--.
//           On last beat (count==1 & valid): go to IDLE, prio <= ~grant.
//   WRITE:  granted port muxed as in ACTIVE, wr only (rd forced 0). Each accepted beat:
//           count--. On accepted beat with count==1: go to IDLE, prio <= ~grant.
//  Completion from ACTIVE (single-beat write) also sets prio <= ~grant.
//  Latency: 1 clock arbitration (IDLE->ACTIVE) before the first command reaches DDR.
//  Back-to-back bursts of the same port therefore have 1 idle cycle between them.
//  Addr/burstCount/mask are sampled from the granted port only when DDR accepts the command.
//  io_in_N_valid is never asserted for the non-granted port.
//  io_ddr_valid in IDLE/ACTIVE/WRITE is ignored (no requester valid).
//  A requester dropping wr mid-burst: WRITE holds (io_ddr_wr=0) until the remaining beats
//  arrive; no timeout.
//  Count is BW bits; burstCount=2^BW-1 is supported without wrap.
//  Reset mid-burst: immediate return to reset state; DDR-side burst is abandoned, and
//  late io_ddr_valid beats are ignored.
// TESTING
//  1. Port0 rd, addr 0x100, burst 4; DDR returns 4 valids -> port0 valid x4,
//     port1 valid never; state IDLE after beat 4.
//  2. Both ports rd same cycle after reset -> port0 granted first; port1 granted next,
//     1 clock after port0's last beat.
//  3. Port1 write burst 3 with io_ddr_waitReq high for 2 cycles on beat 2 -> io_ddr_wr/din
//     held stable, port1 waitReq mirrors DDR, exactly 3 beats accepted.
//  4. Port0 continuously requesting 1-beat reads while port1 requests -> grants alternate
//     0,1,0,1.
//  5. burstCount=0 write -> treated as 1 beat, return to IDLE next cycle.
//  6. Assert reset during READ with 2 beats outstanding -> all outputs to reset values
//     asynchronously; subsequent io_ddr_valid yields no io_in_N_valid.

Source files
------------

// File: rtl/ddr_arbiter.sv
// ---------------------------------------------------------------------------
// ddr_arbiter
//
// Shares one DDR Avalon-style master between two requesters (for example
// port 0 = ROM download / tile fetch, port 1 = frame buffer). A whole burst
// is granted at a time. When both ports want the bus, the port that did not
// finish the last burst wins, so neither side can starve.
//
// Ports
//   clock, reset             system clock, asynchronous active-high reset
//   io_in_N_rd / _wr         read request / write beat valid from port N
//   io_in_N_addr             burst start address
//   io_in_N_burstCount       beats in burst (0 behaves as 1)
//   io_in_N_mask / _din      byte enables / write data
//   io_in_N_waitReq          stall back to port N
//   io_in_N_valid / _dout    read beat valid / read data to port N
//   io_ddr_*                 the shared DDR master interface
// ---------------------------------------------------------------------------
module ddr_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int BURST_WIDTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,

    input  logic                    io_in_0_rd,
    input  logic                    io_in_0_wr,
    input  logic [ADDR_WIDTH-1:0]   io_in_0_addr,
    input  logic [BURST_WIDTH-1:0]  io_in_0_burstCount,
    input  logic [DATA_WIDTH/8-1:0] io_in_0_mask,
    input  logic [DATA_WIDTH-1:0]   io_in_0_din,
    output logic                    io_in_0_waitReq,
    output logic                    io_in_0_valid,
    output logic [DATA_WIDTH-1:0]   io_in_0_dout,

    input  logic                    io_in_1_rd,
    input  logic                    io_in_1_wr,
    input  logic [ADDR_WIDTH-1:0]   io_in_1_addr,
    input  logic [BURST_WIDTH-1:0]  io_in_1_burstCount,
    input  logic [DATA_WIDTH/8-1:0] io_in_1_mask,
    input  logic [DATA_WIDTH-1:0]   io_in_1_din,
    output logic                    io_in_1_waitReq,
    output logic                    io_in_1_valid,
    output logic [DATA_WIDTH-1:0]   io_in_1_dout,

    output logic                    io_ddr_rd,
    output logic                    io_ddr_wr,
    output logic [ADDR_WIDTH-1:0]   io_ddr_addr,
    output logic [BURST_WIDTH-1:0]  io_ddr_burstCount,
    output logic [DATA_WIDTH/8-1:0] io_ddr_mask,
    output logic [DATA_WIDTH-1:0]   io_ddr_din,
    input  logic [DATA_WIDTH-1:0]   io_ddr_dout,
    input  logic                    io_ddr_waitReq,
    input  logic                    io_ddr_valid
);

    localparam logic [BURST_WIDTH-1:0] BurstOne = BURST_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        READ,
        WRITE
    } state_e;

    state_e                   state_q, state_d;
    logic                     grant_q, grant_d;
    logic                     prio_q, prio_d;
    logic [BURST_WIDTH-1:0]   count_q, count_d;

    logic                     grantRd;
    logic                     grantWr;
    logic [ADDR_WIDTH-1:0]    grantAddr;
    logic [BURST_WIDTH-1:0]   grantBurst;
    logic [DATA_WIDTH/8-1:0]  grantMask;
    logic [DATA_WIDTH-1:0]    grantDin;
    logic [BURST_WIDTH-1:0]   grantBurstEff;
    logic                     req0;
    logic                     req1;

    // Read data is simply fanned out; io_in_N_valid decides who consumes it.
    assign io_in_0_dout = io_ddr_dout;
    assign io_in_1_dout = io_ddr_dout;

    assign req0 = io_in_0_rd | io_in_0_wr;
    assign req1 = io_in_1_rd | io_in_1_wr;

    // Select the granted port's command fields.
    always_comb begin
        grantRd    = grant_q ? io_in_1_rd         : io_in_0_rd;
        grantWr    = grant_q ? io_in_1_wr         : io_in_0_wr;
        grantAddr  = grant_q ? io_in_1_addr       : io_in_0_addr;
        grantBurst = grant_q ? io_in_1_burstCount : io_in_0_burstCount;
        grantMask  = grant_q ? io_in_1_mask       : io_in_0_mask;
        grantDin   = grant_q ? io_in_1_din        : io_in_0_din;
        grantBurstEff = (grantBurst == '0) ? BurstOne : grantBurst;
    end

    // State, grant, priority and beat counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            prio_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            prio_q  <= prio_d;
            count_q <= count_d;
        end
    end

    // Next-state logic. Every burst completion hands priority to the other
    // port, which gives round-robin behaviour when both keep requesting.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        prio_d  = prio_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    grant_d = (req0 && req1) ? prio_q : req1;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (grantRd && !io_ddr_waitReq) begin
                    count_d = grantBurstEff;
                    state_d = READ;
                end else if (grantWr && !io_ddr_waitReq) begin
                    // First write beat is accepted here; a 0/1-beat burst is
                    // already complete.
                    if (grantBurst <= BurstOne) begin
                        count_d = '0;
                        prio_d  = ~grant_q;
                        state_d = IDLE;
                    end else begin
                        count_d = grantBurst - BurstOne;
                        state_d = WRITE;
                    end
                end
            end
            READ: begin
                if (io_ddr_valid) begin
                    count_d = count_q - BurstOne;
                    if (count_q == BurstOne) begin
                        prio_d  = ~grant_q;
                        state_d = IDLE;
                    end
                end
            end
            WRITE: begin
                if (grantWr && !io_ddr_waitReq) begin
                    count_d = count_q - BurstOne;
                    if (count_q == BurstOne) begin
                        prio_d  = ~grant_q;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic. Command fields always follow the granted port; only the
    // strobes, stalls and read valids depend on the state.
    always_comb begin
        io_ddr_rd         = 1'b0;
        io_ddr_wr         = 1'b0;
        io_ddr_addr       = grantAddr;
        io_ddr_burstCount = grantBurst;
        io_ddr_mask       = grantMask;
        io_ddr_din        = grantDin;
        io_in_0_waitReq   = 1'b1;
        io_in_1_waitReq   = 1'b1;
        io_in_0_valid     = 1'b0;
        io_in_1_valid     = 1'b0;
        unique case (state_q)
            ACTIVE: begin
                io_ddr_rd = grantRd;
                io_ddr_wr = grantWr;
                if (grant_q) io_in_1_waitReq = io_ddr_waitReq;
                else         io_in_0_waitReq = io_ddr_waitReq;
            end
            READ: begin
                if (grant_q) io_in_1_valid = io_ddr_valid;
                else         io_in_0_valid = io_ddr_valid;
            end
            WRITE: begin
                // Reads cannot start mid write burst.
                io_ddr_wr = grantWr;
                if (grant_q) io_in_1_waitReq = io_ddr_waitReq;
                else         io_in_0_waitReq = io_ddr_waitReq;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_ddr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ddr_arbiter
//
// Cycle-stepped bench for ddr_arbiter. Two randomised requesters and a
// randomised DDR slave are driven from one initial block. A transaction-level
// reference (which port owns the bus, whether its command has been taken,
// how many beats remain, who has priority) predicts every DUT output.
// ---------------------------------------------------------------------------
module tb_ddr_arbiter;

    logic        clock = 1'b0;
    logic        reset;

    logic [1:0]  inRd;
    logic [1:0]  inWr;
    logic [31:0] inAddr [2];
    logic [7:0]  inBc   [2];
    logic [7:0]  inMask [2];
    logic [63:0] inDin  [2];
    logic [1:0]  inWait;
    logic [1:0]  inValid;
    logic [63:0] dout0;
    logic [63:0] dout1;

    logic        ddrRd;
    logic        ddrWr;
    logic [31:0] ddrAddr;
    logic [7:0]  ddrBc;
    logic [7:0]  ddrMask;
    logic [63:0] ddrDin;
    logic [63:0] ddrDout;
    logic        ddrWait;
    logic        ddrValid;

    int checks   = 0;
    int failures = 0;

    // Requester-side bookkeeping
    bit rqBusy    [2];
    bit rqWrite   [2];
    bit rqCmdDone [2];
    int rqLeft    [2];

    // DDR slave bookkeeping
    int ddrPending;

    // Reference: bus owner (-1 = free), command taken, read/write, beats left
    int mOwner;
    bit mCmdDone;
    bit mIsRead;
    int mLeft;
    int mPrio;

    // Stimulus knobs (percentages)
    int reqProb [2];
    int wrProb;
    int waitProb;
    int validProb;
    int spurProb;
    int dropProb;
    int fixedBc;

    ddr_arbiter dut (
        .clock              (clock),
        .reset              (reset),
        .io_in_0_rd         (inRd[0]),
        .io_in_0_wr         (inWr[0]),
        .io_in_0_addr       (inAddr[0]),
        .io_in_0_burstCount (inBc[0]),
        .io_in_0_mask       (inMask[0]),
        .io_in_0_din        (inDin[0]),
        .io_in_0_waitReq    (inWait[0]),
        .io_in_0_valid      (inValid[0]),
        .io_in_0_dout       (dout0),
        .io_in_1_rd         (inRd[1]),
        .io_in_1_wr         (inWr[1]),
        .io_in_1_addr       (inAddr[1]),
        .io_in_1_burstCount (inBc[1]),
        .io_in_1_mask       (inMask[1]),
        .io_in_1_din        (inDin[1]),
        .io_in_1_waitReq    (inWait[1]),
        .io_in_1_valid      (inValid[1]),
        .io_in_1_dout       (dout1),
        .io_ddr_rd          (ddrRd),
        .io_ddr_wr          (ddrWr),
        .io_ddr_addr        (ddrAddr),
        .io_ddr_burstCount  (ddrBc),
        .io_ddr_mask        (ddrMask),
        .io_ddr_din         (ddrDin),
        .io_ddr_dout        (ddrDout),
        .io_ddr_waitReq     (ddrWait),
        .io_ddr_valid       (ddrValid)
    );

    always #5 clock = ~clock;

    function automatic int effBc(input logic [7:0] b);
        return (b == 8'd0) ? 1 : int'(b);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic resetBench();
        for (int p = 0; p < 2; p++) begin
            rqBusy[p]    = 1'b0;
            rqWrite[p]   = 1'b0;
            rqCmdDone[p] = 1'b0;
            rqLeft[p]    = 0;
            inAddr[p]    = '0;
            inBc[p]      = '0;
            inMask[p]    = '0;
            inDin[p]     = '0;
        end
        inRd       = '0;
        inWr       = '0;
        ddrWait    = 1'b0;
        ddrValid   = 1'b0;
        ddrDout    = '0;
        ddrPending = 0;
        mOwner     = -1;
        mCmdDone   = 1'b0;
        mIsRead    = 1'b0;
        mLeft      = 0;
        mPrio      = 0;
    endtask

    task automatic doReset();
        reset    = 1'b1;
        inRd     = 2'b11;
        inWr     = 2'b00;
        ddrValid = 1'b1;
        ddrWait  = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        checkOutput("rst_ddr_rd",  64'(ddrRd),   64'd0);
        checkOutput("rst_ddr_wr",  64'(ddrWr),   64'd0);
        checkOutput("rst_waitReq", 64'(inWait),  64'd3);
        checkOutput("rst_valid",   64'(inValid), 64'd0);
        reset = 1'b0;
        resetBench();
    endtask

    // One clock cycle: drive inputs after the falling edge, compare every
    // output with the reference, then advance requesters, slave and reference.
    task automatic applyStimulus();
        logic       expRd;
        logic       expWr;
        logic [1:0] expWait;
        logic [1:0] expValid;
        bit         checkMux;
        int         o;
        @(negedge clock);
        for (int p = 0; p < 2; p++) begin
            if (!rqBusy[p] && $urandom_range(99) < reqProb[p]) begin
                rqBusy[p]    = 1'b1;
                rqWrite[p]   = ($urandom_range(99) < wrProb);
                rqCmdDone[p] = 1'b0;
                inAddr[p]    = $urandom & 32'hFFFF_FFF8;
                inBc[p]      = (fixedBc >= 0) ? 8'(fixedBc) : 8'($urandom_range(0, 6));
                inMask[p]    = 8'($urandom);
                inDin[p]     = {$urandom, $urandom};
                rqLeft[p]    = effBc(inBc[p]);
            end
            inRd[p] = rqBusy[p] && !rqWrite[p] && !rqCmdDone[p];
            inWr[p] = rqBusy[p] && rqWrite[p] && ($urandom_range(99) >= dropProb);
        end
        ddrWait  = ($urandom_range(99) < waitProb);
        ddrValid = (ddrPending > 0) ? ($urandom_range(99) < validProb)
                                    : ($urandom_range(99) < spurProb);
        ddrDout  = {$urandom, $urandom};
        #1;

        expRd    = 1'b0;
        expWr    = 1'b0;
        expWait  = 2'b11;
        expValid = 2'b00;
        checkMux = 1'b0;
        o        = mOwner;
        if (o >= 0) begin
            if (!mCmdDone) begin
                expRd      = inRd[o];
                expWr      = inWr[o];
                expWait[o] = ddrWait;
                checkMux   = 1'b1;
            end else if (mIsRead) begin
                expValid[o] = ddrValid;
            end else begin
                expWr      = inWr[o];
                expWait[o] = ddrWait;
                checkMux   = 1'b1;
            end
        end
        checkOutput("ddr_rd",  64'(ddrRd),   64'(expRd));
        checkOutput("ddr_wr",  64'(ddrWr),   64'(expWr));
        checkOutput("waitReq", 64'(inWait),  64'(expWait));
        checkOutput("valid",   64'(inValid), 64'(expValid));
        checkOutput("dout0",   dout0, ddrDout);
        checkOutput("dout1",   dout1, ddrDout);
        if (checkMux) begin
            checkOutput("ddr_addr", 64'(ddrAddr), 64'(inAddr[o]));
            checkOutput("ddr_bc",   64'(ddrBc),   64'(inBc[o]));
            checkOutput("ddr_mask", 64'(ddrMask), 64'(inMask[o]));
            checkOutput("ddr_din",  ddrDin, inDin[o]);
        end

        // Reference update, from the inputs only
        if (o < 0) begin
            if ((inRd[0] | inWr[0]) && (inRd[1] | inWr[1])) mOwner = mPrio;
            else if (inRd[0] | inWr[0])                     mOwner = 0;
            else if (inRd[1] | inWr[1])                     mOwner = 1;
            mCmdDone = 1'b0;
        end else if (!mCmdDone) begin
            if (inRd[o] && !ddrWait) begin
                mCmdDone = 1'b1;
                mIsRead  = 1'b1;
                mLeft    = effBc(inBc[o]);
            end else if (inWr[o] && !ddrWait) begin
                mLeft    = effBc(inBc[o]) - 1;
                mCmdDone = 1'b1;
                mIsRead  = 1'b0;
            end
        end else if (mIsRead) begin
            if (ddrValid) mLeft--;
        end else begin
            if (inWr[o] && !ddrWait) mLeft--;
        end
        if (o >= 0 && mCmdDone && mLeft == 0) begin
            mOwner   = -1;
            mCmdDone = 1'b0;
            mPrio    = 1 - o;
        end

        // Requesters react to the arbiter's handshake
        for (int p = 0; p < 2; p++) begin
            if (inRd[p] && !inWait[p]) rqCmdDone[p] = 1'b1;
            if (inWr[p] && !inWait[p]) begin
                rqLeft[p]--;
                inDin[p] = {$urandom, $urandom};
                if (rqLeft[p] == 0) rqBusy[p] = 1'b0;
            end
            if (rqBusy[p] && !rqWrite[p] && inValid[p]) begin
                rqLeft[p]--;
                if (rqLeft[p] == 0) rqBusy[p] = 1'b0;
            end
        end

        // DDR slave: queue read beats for each accepted read command
        if (ddrValid && ddrPending > 0) ddrPending--;
        if (ddrRd && !ddrWait) ddrPending += effBc(ddrBc);
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    task automatic drain(input string tag);
        bit done;
        reqProb[0] = 0;
        reqProb[1] = 0;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            applyStimulus();
            done = !rqBusy[0] && !rqBusy[1] && ddrPending == 0 && mOwner < 0;
        end
        checkOutput(tag, 64'(done), 64'd1);
    endtask

    task automatic setKnobs(input int r0, input int r1, input int wr, input int wt,
                            input int vl, input int bc, input int drop);
        reqProb[0] = r0;
        reqProb[1] = r1;
        wrProb     = wr;
        waitProb   = wt;
        validProb  = vl;
        fixedBc    = bc;
        dropProb   = drop;
        spurProb   = 5;
    endtask

    initial begin
        bit reached;
        resetBench();
        setKnobs(0, 0, 0, 0, 100, -1, 0);
        doReset();

        // Single port-0 read burst of 4
        setKnobs(100, 0, 0, 0, 100, 4, 0);
        applyStimulus();
        drain("drain_rd4");

        // Both ports reading together: port 0 first, then alternation
        doReset();
        setKnobs(100, 100, 0, 20, 70, 4, 0);
        runCycles(60);
        drain("drain_both_rd4");
        setKnobs(100, 100, 0, 0, 100, 1, 0);
        runCycles(40);
        drain("drain_alt_rd1");

        // Port-1 write bursts of 3 with DDR stalls, then 0-beat writes
        setKnobs(0, 100, 100, 40, 100, 3, 0);
        runCycles(60);
        drain("drain_wr3");
        setKnobs(30, 100, 100, 20, 100, 0, 0);
        runCycles(60);
        drain("drain_wr0");

        // Maximum-length read and write bursts
        setKnobs(100, 0, 0, 20, 60, 255, 0);
        applyStimulus();
        drain("drain_rd255");
        setKnobs(0, 100, 100, 20, 60, 255, 10);
        applyStimulus();
        drain("drain_wr255");

        // Random mix with stalls, gaps and dropped write beats
        setKnobs(60, 60, 50, 30, 60, -1, 15);
        runCycles(3000);
        drain("drain_random");

        // Reset while a port-0 read still has 2 beats outstanding
        setKnobs(100, 0, 0, 0, 50, 4, 0);
        applyStimulus();
        reqProb[0] = 0;
        reached = 1'b0;
        for (int i = 0; i < 100 && !reached; i++) begin
            applyStimulus();
            reached = rqBusy[0] && rqCmdDone[0] && rqLeft[0] == 2;
        end
        checkOutput("mid_read_reached", 64'(reached), 64'd1);
        ddrValid = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        checkOutput("async_rst_ddr_rd",  64'(ddrRd),   64'd0);
        checkOutput("async_rst_waitReq", 64'(inWait),  64'd3);
        checkOutput("async_rst_valid",   64'(inValid), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        resetBench();
        setKnobs(0, 0, 0, 0, 100, -1, 0);
        spurProb = 100;
        runCycles(4);

        // Traffic after the abandoned burst
        setKnobs(60, 60, 50, 30, 60, -1, 10);
        runCycles(500);
        drain("drain_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
